// File: rtl/ling_lf_subtractor_pipe_if.sv
// Operand/result channel of the pipelined Ling subtractor: valid/ready on both sides.
interface ling_lf_subtractor_pipe_if #(
    parameter int unsigned WIDTH = 14
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf
    );
endinterface

// File: rtl/ling_lf_subtractor_pipe.sv
// Two-stage valid/ready pipelined 14-bit subtractor: diff = a - b - bin, computed as
// a + ~b + ~bin on a Ling Ladner-Fischer prefix tree, with borrow-out and signed overflow.
module ling_lf_subtractor_pipe #(
    parameter int unsigned WIDTH = 14
) (
    input  logic                     clk,
    input  logic                     rst,
    ling_lf_subtractor_pipe_if.slave bus
);
    localparam int unsigned W  = WIDTH;
    localparam int unsigned NP = W + 1;   // prefix positions; position 0 is the carry-in slot
    localparam int unsigned NG = W / 2;   // odd-position pair groups

    logic adv_a_c;
    logic adv_b_c;
    logic va_q;
    logic va_d;
    logic vb_q;
    logic vb_d;

    // Each stage advances when empty or when its downstream advances; bubbles collapse.
    assign adv_b_c      = !vb_q || bus.out_ready;
    assign adv_a_c      = !va_q || adv_b_c;
    assign bus.in_ready = adv_a_c && !rst;
    assign va_d         = adv_a_c ? bus.in_valid : va_q;
    assign vb_d         = adv_b_c ? va_q : vb_q;

    logic [W-1:0]  bb_c;
    logic [NP-1:1] p_c;
    logic [NP-1:0] g_c;
    logic [NG-1:0] hp_d;
    logic [NG-1:0] hp_q;
    logic [NG-1:1] ip_d;
    logic [NG-1:1] ip_q;
    logic [NP-1:1] p_q;
    logic [NP-1:0] g_q;
    logic          sa_q;
    logic          sb_q;

    assign bb_c = ~bus.b;
    assign p_c  = bus.a | bb_c;
    assign g_c  = {bus.a & bb_c, ~bus.bin};

    // First Ling level over odd pairs: H = g[i]|g[i-1], I = p[i-1]&p[i-2].
    always_comb begin
        hp_d = '0;
        ip_d = '0;
        for (int m = 0; m < int'(NG); m++) begin
            hp_d[m] = g_c[2*m+1] | g_c[2*m];
        end
        for (int m = 1; m < int'(NG); m++) begin
            ip_d[m] = p_c[2*m] & p_c[2*m-1];
        end
    end

    logic [NP-1:0] pp_c;
    logic          h3_0;
    logic          h7_4;
    logic          i7_4;
    logic          h11_8;
    logic          i11_8;
    logic          h5_0;
    logic          h7_0;
    logic          h13_8;
    logic          i13_8;
    logic          h9_0;
    logic          h11_0;
    logic          h13_0;
    logic [NG-1:0] hodd_c;
    logic [NP-1:0] h_c;
    logic [NP:1]   c_c;
    logic [W-1:0]  diff_d;
    logic [W-1:0]  diff_q;
    logic          bout_d;
    logic          bout_q;
    logic          ovf_d;
    logic          ovf_q;

    assign pp_c = {p_q, 1'b1};

    // Ladner-Fischer spans of 4, 8 and 16 bits over the registered pair terms.
    assign h3_0   = hp_q[1] | (ip_q[1] & hp_q[0]);
    assign h7_4   = hp_q[3] | (ip_q[3] & hp_q[2]);
    assign i7_4   = ip_q[3] & ip_q[2];
    assign h11_8  = hp_q[5] | (ip_q[5] & hp_q[4]);
    assign i11_8  = ip_q[5] & ip_q[4];
    assign h5_0   = hp_q[2] | (ip_q[2] & h3_0);
    assign h7_0   = h7_4 | (i7_4 & h3_0);
    assign h13_8  = hp_q[6] | (ip_q[6] & h11_8);
    assign i13_8  = ip_q[6] & i11_8;
    assign h9_0   = hp_q[4] | (ip_q[4] & h7_0);
    assign h11_0  = h11_8 | (i11_8 & h7_0);
    assign h13_0  = h13_8 | (i13_8 & h7_0);
    assign hodd_c = {h13_0, h11_0, h9_0, h7_0, h5_0, h3_0, hp_q[0]};

    // Extra grey stage: even positions fold their own g onto the odd prefix below.
    always_comb begin
        h_c    = '0;
        h_c[0] = g_q[0];
        for (int k = 1; k < int'(NP); k++) begin
            if (k % 2 == 1) begin
                h_c[k] = hodd_c[(k-1)/2];
            end else begin
                h_c[k] = g_q[k] | (pp_c[k-1] & hodd_c[(k-2)/2]);
            end
        end
    end

    always_comb begin
        c_c = '0;
        for (int k = 1; k <= int'(NP); k++) begin
            c_c[k] = pp_c[k-1] & h_c[k-1];
        end
    end

    always_comb begin
        diff_d = '0;
        for (int k = 1; k < int'(NP); k++) begin
            diff_d[k-1] = (pp_c[k] & ~g_q[k]) ^ c_c[k];
        end
    end

    assign bout_d = ~c_c[NP];
    assign ovf_d  = (sa_q != sb_q) && (diff_d[W-1] != sa_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            va_q   <= 1'b0;
            vb_q   <= 1'b0;
            hp_q   <= '0;
            ip_q   <= '0;
            p_q    <= '0;
            g_q    <= '0;
            sa_q   <= 1'b0;
            sb_q   <= 1'b0;
            diff_q <= '0;
            bout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            va_q <= va_d;
            vb_q <= vb_d;
            if (adv_a_c) begin
                hp_q <= hp_d;
                ip_q <= ip_d;
                p_q  <= p_c;
                g_q  <= g_c;
                sa_q <= bus.a[W-1];
                sb_q <= bus.b[W-1];
            end
            if (adv_b_c) begin
                diff_q <= diff_d;
                bout_q <= bout_d;
                ovf_q  <= ovf_d;
            end
        end
    end

    assign bus.out_valid = vb_q;
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_ling_lf_subtractor_pipe.sv
// Bench for ling_lf_subtractor_pipe: directed vector table, backpressure and reset
// sequences, then random traffic against an integer-arithmetic reference.
module tb_ling_lf_subtractor_pipe;
    localparam int unsigned W = 14;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ling_lf_subtractor_pipe_if #(.WIDTH(W)) bus ();
    ling_lf_subtractor_pipe #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [13:0] a;
        logic [13:0] b;
        logic        bin;
        logic [13:0] diff;
        logic        bout;
        logic        ovf;
    } vec_t;

    vec_t        vecs[9];
    int          bp_rdy[5] = '{1, 1, 0, 0, 0};
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];
    logic        held;
    logic [15:0] prev_out;
    logic [15:0] cur_out;
    int          acc;
    int          got_n;
    int          prev_cyc;
    int          quiet_bad;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer subtraction; overflow from the signed result range.
    function automatic logic [15:0] ref_sub(input logic [13:0] a, input logic [13:0] b,
                                            input logic bin);
        int ud;
        int sa;
        int sb;
        int sd;
        ud = int'(a) - int'(b) - int'(bin);
        sa = (int'(a) >= 8192) ? int'(a) - 16384 : int'(a);
        sb = (int'(b) >= 8192) ? int'(b) - 16384 : int'(b);
        sd = sa - sb - int'(bin);
        return {(sd < -8192) || (sd > 8191), ud < 0, 14'(ud)};
    endfunction

    function automatic logic [13:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 14'h0000;
            1:       return 14'h3FFF;
            2:       return 14'h2000;
            3:       return 14'h1FFF;
            default: return 14'($urandom);
        endcase
    endfunction

    task automatic idle(input int n);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic run_one(input string tag, input logic [13:0] a, input logic [13:0] b,
                           input logic bin, input logic [13:0] ed, input logic eb,
                           input logic eo);
        @(negedge clk);
        bus.a         = a;
        bus.b         = b;
        bus.bin       = bin;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk({tag, "_in_ready"}, int'(bus.in_ready), 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        chk({tag, "_early_valid"}, int'(bus.out_valid), 0);
        @(negedge clk);
        #1;
        chk({tag, "_valid"}, int'(bus.out_valid), 1);
        chk({tag, "_diff"}, int'(bus.diff), int'(ed));
        chk({tag, "_bout"}, int'(bus.bout), int'(eb));
        chk({tag, "_ovf"}, int'(bus.ovf), int'(eo));
    endtask

    task automatic retire_check();
        logic [15:0] o;
        logic [15:0] e;
        o = {bus.ovf, bus.bout, bus.diff};
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("rnd_spurious_out", int'(bus.out_valid), 0);
            end else begin
                e = exp_q.pop_front();
                chk("rnd_result", int'(o), int'(e));
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{14'd100,   14'd37,    1'b0, 14'd63,    1'b0, 1'b0};
        vecs[1] = '{14'h0000,  14'h0001,  1'b0, 14'h3FFF,  1'b1, 1'b0};
        vecs[2] = '{14'h0000,  14'h0000,  1'b1, 14'h3FFF,  1'b1, 1'b0};
        vecs[3] = '{14'h2000,  14'h0001,  1'b0, 14'h1FFF,  1'b0, 1'b1};
        vecs[4] = '{14'h1FFF,  14'h3FFF,  1'b0, 14'h2000,  1'b1, 1'b1};
        vecs[5] = '{14'h3FFF,  14'h3FFF,  1'b1, 14'h3FFF,  1'b1, 1'b0};
        vecs[6] = '{14'h0000,  14'h0000,  1'b0, 14'h0000,  1'b0, 1'b0};
        vecs[7] = '{14'h3FFF,  14'h0000,  1'b1, 14'h3FFE,  1'b0, 1'b0};
        vecs[8] = '{14'h1234,  14'h0234,  1'b0, 14'h1000,  1'b0, 1'b0};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.bin       = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_diff", int'(bus.diff), 0);
        chk("rst_bout", int'(bus.bout), 0);
        chk("rst_ovf", int'(bus.ovf), 0);
        chk("rst_in_ready", int'(bus.in_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", int'(bus.in_ready), 1);

        for (int i = 0; i < 9; i++) begin
            run_one($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bin,
                    vecs[i].diff, vecs[i].bout, vecs[i].ovf);
        end

        // Backpressure: a=10..13, b=1 offered with the consumer stalled for 5 cycles.
        idle(3);
        acc = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            bus.a         = 14'(10 + acc);
            bus.b         = 14'd1;
            bus.bin       = 1'b0;
            bus.in_valid  = 1'b1;
            bus.out_ready = 1'b0;
            #1;
            chk($sformatf("bp_in_ready_c%0d", cyc), int'(bus.in_ready), bp_rdy[cyc]);
            if (cyc >= 2) begin
                chk("bp_hold_valid", int'(bus.out_valid), 1);
                chk("bp_hold_diff", int'(bus.diff), 9);
            end else begin
                chk("bp_out_valid", int'(bus.out_valid), 0);
            end
            if (bus.in_ready) acc++;
            @(negedge clk);
        end
        chk("bp_accepted", acc, 2);
        got_n    = 0;
        prev_cyc = 0;
        for (int cyc = 0; cyc < 20 && got_n < 4; cyc++) begin
            bus.a         = 14'(10 + acc);
            bus.in_valid  = (acc < 4);
            bus.out_ready = 1'b1;
            #1;
            if (bus.out_valid) begin
                chk("bp_order", int'(bus.diff), 9 + got_n);
                if (got_n > 0) chk("bp_back_to_back", cyc, prev_cyc + 1);
                prev_cyc = cyc;
                got_n++;
            end
            if (bus.in_valid && bus.in_ready) acc++;
            @(negedge clk);
        end
        chk("bp_drained", got_n, 4);

        // Reset with two operands in flight.
        idle(3);
        bus.a         = 14'd20;
        bus.b         = 14'd3;
        bus.bin       = 1'b0;
        bus.in_valid  = 1'b1;
        #1;
        chk("rf_accept0", int'(bus.in_ready), 1);
        @(negedge clk);
        bus.a = 14'd30;
        #1;
        chk("rf_accept1", int'(bus.in_ready), 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        #1;
        chk("rf_in_ready_in_rst", int'(bus.in_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rf_out_valid", int'(bus.out_valid), 0);
        chk("rf_diff", int'(bus.diff), 0);
        chk("rf_bout", int'(bus.bout), 0);
        chk("rf_ovf", int'(bus.ovf), 0);
        chk("rf_in_ready", int'(bus.in_ready), 1);
        quiet_bad = 0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            #1;
            if (bus.out_valid) quiet_bad++;
        end
        chk("rf_no_stale", quiet_bad, 0);
        run_one("rf_new", 14'd5, 14'd5, 1'b0, 14'd0, 1'b0, 1'b0);

        // Random traffic with random backpressure, scoreboarded against ref_sub.
        idle(3);
        held     = 1'b0;
        prev_out = '0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.a         = pick_operand();
            bus.b         = pick_operand();
            bus.bin       = 1'($urandom_range(0, 1));
            #1;
            cur_out = {bus.ovf, bus.bout, bus.diff};
            if (held) begin
                chk("rnd_hold_valid", int'(bus.out_valid), 1);
                chk("rnd_hold_data", int'(cur_out), int'(prev_out));
            end
            retire_check();
            if (bus.in_valid && bus.in_ready) exp_q.push_back(ref_sub(bus.a, bus.b, bus.bin));
            held     = bus.out_valid && !bus.out_ready;
            prev_out = cur_out;
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 8 && exp_q.size() > 0; cyc++) begin
            #1;
            retire_check();
            @(negedge clk);
        end
        chk("rnd_drained", int'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
